// File: rtl/fp_div_arb_pkg.sv
// Shared constants for the FP divider arbiter: float width, settle-counter
// width and the controller state encoding.
package fp_div_arb_pkg;

  localparam int FP_W  = 32;
  localparam int CNT_W = $clog2(15 + 1);

  // State encoding kept as plain constants so older tools and netlists match
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/FP_Div.sv
// Combinational IEEE-754 single-precision divider, round-to-nearest-even,
// with subnormal inputs/outputs and a canonical quiet NaN for invalid cases.
module FP_Div (
  input  logic [31:0] in_numA,
  input  logic [31:0] in_numB,
  output logic [31:0] out_result
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) n = 5'(23 - i);
    return n;
  endfunction

  logic               w_signQ;
  logic [7:0]         w_expA, w_expB;
  logic               w_nanA, w_nanB, w_infA, w_infB, w_zeroA, w_zeroB;
  logic [23:0]        w_rawA, w_rawB, w_sigA, w_sigB;
  logic [4:0]         w_lzA, w_lzB;
  logic signed [10:0] w_eA, w_eB, w_eQ, w_eNorm;
  logic [49:0]        w_num, w_den;
  logic [26:0]        w_quot;
  logic [23:0]        w_rem;
  logic [25:0]        w_ext;

  assign w_signQ = in_numA[31] ^ in_numB[31];
  assign w_expA  = in_numA[30:23];
  assign w_expB  = in_numB[30:23];
  assign w_nanA  = (w_expA == 8'hFF) && (in_numA[22:0] != 23'd0);
  assign w_nanB  = (w_expB == 8'hFF) && (in_numB[22:0] != 23'd0);
  assign w_infA  = (w_expA == 8'hFF) && (in_numA[22:0] == 23'd0);
  assign w_infB  = (w_expB == 8'hFF) && (in_numB[22:0] == 23'd0);
  assign w_zeroA = (w_expA == 8'd0) && (in_numA[22:0] == 23'd0);
  assign w_zeroB = (w_expB == 8'd0) && (in_numB[22:0] == 23'd0);

  // Subnormals are normalised up front so the divider always sees 1.x / 1.x
  assign w_rawA = {w_expA != 8'd0, in_numA[22:0]};
  assign w_rawB = {w_expB != 8'd0, in_numB[22:0]};
  assign w_lzA  = lzc24(w_rawA);
  assign w_lzB  = lzc24(w_rawB);
  assign w_sigA = w_rawA << w_lzA;
  assign w_sigB = w_rawB << w_lzB;
  assign w_eA   = $signed({3'b000, (w_expA == 8'd0) ? 8'd1 : w_expA}) - $signed({6'd0, w_lzA});
  assign w_eB   = $signed({3'b000, (w_expB == 8'd0) ? 8'd1 : w_expB}) - $signed({6'd0, w_lzB});

  assign w_num  = {w_sigA, 26'd0};
  assign w_den  = {26'd0, w_sigB};
  assign w_quot = 27'(w_num / w_den);
  assign w_rem  = 24'(w_num % w_den);
  assign w_eQ   = w_eA - w_eB + 11'sd127;

  always_comb begin
    if (w_quot[26]) begin
      w_eNorm = w_eQ;
      w_ext   = {w_quot[26:3], w_quot[2], (|w_quot[1:0]) | (w_rem != 24'd0)};
    end else begin
      w_eNorm = w_eQ - 11'sd1;
      w_ext   = {w_quot[25:2], w_quot[1], w_quot[0] | (w_rem != 24'd0)};
    end
  end

  logic               w_denorm, w_lost, w_roundUp;
  logic signed [10:0] w_shamt, w_eFinal;
  logic [25:0]        w_shifted;
  logic [24:0]        w_rounded;

  // Underflowing results are shifted into subnormal range before rounding
  always_comb begin
    w_shamt   = 11'sd1 - w_eNorm;
    w_denorm  = w_eNorm < 11'sd1;
    w_shifted = w_ext;
    w_lost    = 1'b0;
    if (w_denorm) begin
      if (w_shamt > 11'sd25) begin
        w_shifted = '0;
        w_lost    = |w_ext;
      end else begin
        w_shifted = w_ext >> w_shamt[4:0];
        w_lost    = |(w_ext & ((26'd1 << w_shamt[4:0]) - 26'd1));
      end
    end
    w_roundUp = w_shifted[1] & (w_shifted[0] | w_lost | w_shifted[2]);
    w_rounded = {1'b0, w_shifted[25:2]} + {24'd0, w_roundUp};
    w_eFinal  = w_rounded[24] ? w_eNorm + 11'sd1 : w_eNorm;
  end

  always_comb begin
    if (w_nanA || w_nanB || (w_infA && w_infB) || (w_zeroA && w_zeroB))
      out_result = QNAN;
    else if (w_infA || w_zeroB)
      out_result = {w_signQ, 8'hFF, 23'd0};
    else if (w_zeroA || w_infB)
      out_result = {w_signQ, 31'd0};
    else if (w_denorm)
      out_result = {w_signQ, 7'd0, w_rounded[23], w_rounded[22:0]};
    else if (w_eFinal > 11'sd254)
      out_result = {w_signQ, 8'hFF, 23'd0};
    else
      out_result = {w_signQ, w_eFinal[7:0], w_rounded[22:0]};
  end

endmodule

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester after
// the previous winner, wrapping around, and returns the first one asserted.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] in_req,
  input  logic [IDX_W-1:0] in_lastGrant,
  output logic [N_REQ-1:0] out_grant,
  output logic [IDX_W-1:0] out_idx
);

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Offset 1 first so the previous winner is considered last
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(in_lastGrant) + k) % N_REQ);
      if (!w_found && in_req[w_cand]) begin
        w_found         = 1'b1;
        w_idx           = w_cand;
        w_grant[w_cand] = 1'b1;
      end
    end
  end

  assign out_grant = w_grant;
  assign out_idx   = w_idx;

endmodule

// File: rtl/fp_div_arbiter.sv
// Round-robin front end that time-shares one combinational FP_Div between
// several requesters, holding operands stable for a fixed settle window.
module fp_div_arbiter
  import fp_div_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic [N_REQ-1:0]      in_req,
  input  logic [N_REQ*FP_W-1:0] in_numA,
  input  logic [N_REQ*FP_W-1:0] in_numB,
  input  logic [N_REQ-1:0]      in_rdy,
  output logic [N_REQ-1:0]      out_ack,
  output logic [N_REQ-1:0]      out_valid,
  output logic [FP_W-1:0]       out_result,
  output logic                  out_busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_lastGrant;
  logic [N_REQ-1:0] r_grantVec;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_valid;
  logic [FP_W-1:0]  r_opA;
  logic [FP_W-1:0]  r_opB;
  logic [FP_W-1:0]  r_result;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grantIdx;
  logic [FP_W-1:0]  w_quotient;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .in_req       (in_req),
    .in_lastGrant (r_lastGrant),
    .out_grant    (w_grant),
    .out_idx      (w_grantIdx)
  );

  FP_Div u_div (
    .in_numA    (r_opA),
    .in_numB    (r_opB),
    .out_result (w_quotient)
  );

  // Operand regs only load in IDLE, so the divider inputs stay frozen while
  // its long combinational path settles and while the result waits for rdy
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_lastGrant <= IDX_W'(N_REQ - 1);
      r_grantVec  <= '0;
      r_ack       <= '0;
      r_valid     <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_result    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|in_req) begin
            r_opA       <= in_numA[int'(w_grantIdx)*FP_W +: FP_W];
            r_opB       <= in_numB[int'(w_grantIdx)*FP_W +: FP_W];
            r_lastGrant <= w_grantIdx;
            r_grantVec  <= w_grant;
            r_ack       <= w_grant;
            r_cnt       <= CNT_W'(WAIT_CYCLES - 1);
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_result <= w_quotient;
            r_valid  <= r_grantVec;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (in_rdy[r_lastGrant]) begin
            r_valid <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_ack    = r_ack;
  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Randomised self-checking bench for fp_div_arbiter against a transaction
// level model of round-robin order, latency and exact quotients.
module tb_fp_div_arbiter;

  localparam int N_REQ       = 4;
  localparam int WAIT_CYCLES = 3;
  localparam int FP_W        = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0]      rdy;
  logic [N_REQ*FP_W-1:0] numA;
  logic [N_REQ*FP_W-1:0] numB;
  logic [N_REQ-1:0]      ack;
  logic [N_REQ-1:0]      valid;
  logic [FP_W-1:0]       result;
  logic                  busy;

  logic [31:0] opA  [N_REQ];
  logic [31:0] opB  [N_REQ];
  logic [31:0] expQ [N_REQ];
  int lastGrant;
  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  fp_div_arbiter #(
    .N_REQ       (N_REQ),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .in_clk     (clk),
    .in_rst     (rst),
    .in_req     (req),
    .in_numA    (numA),
    .in_numB    (numB),
    .in_rdy     (rdy),
    .out_ack    (ack),
    .out_valid  (valid),
    .out_result (result),
    .out_busy   (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N_REQ; i++) begin
      numA[i*FP_W +: FP_W] = opA[i];
      numB[i*FP_W +: FP_W] = opB[i];
    end
  endtask

  // Exact float for mant * 2^e2 (mant small enough to fit the significand)
  function automatic logic [31:0] mkFloat(input bit s, input int mant, input int e2);
    logic [31:0] m;
    logic [7:0]  ef;
    int p;
    m = mant;
    p = 0;
    for (int i = 0; i < 32; i++)
      if (m[i]) p = i;
    ef = 8'(e2 + p + 127);
    m  = m << (23 - p);
    return {s, ef, m[22:0]};
  endfunction

  function automatic int refPick(input logic [N_REQ-1:0] mask, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (mask[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  // Picks operands whose quotient is exactly known without any rounding
  task automatic randomOperands(input int lane);
    int m1, m2, e1, e2, kind;
    bit s1, s2;
    m1   = $urandom_range(1, 255);
    m2   = $urandom_range(1, 255);
    e1   = int'($urandom_range(0, 40)) - 20;
    e2   = int'($urandom_range(0, 40)) - 20;
    s1   = 1'($urandom_range(0, 1));
    s2   = 1'($urandom_range(0, 1));
    kind = $urandom_range(0, 7);
    if (kind == 0) begin
      opA[lane]  = mkFloat(s1, m1, e1);
      opB[lane]  = {s2, 31'd0};
      expQ[lane] = {s1 ^ s2, 8'hFF, 23'd0};
    end else if (kind == 1) begin
      opA[lane]  = {s1, 31'd0};
      opB[lane]  = mkFloat(s2, m2, e2);
      expQ[lane] = {s1 ^ s2, 31'd0};
    end else begin
      opA[lane]  = mkFloat(s1, m1 * m2, e1 + e2);
      opB[lane]  = mkFloat(s2, m2, e2);
      expQ[lane] = mkFloat(s1 ^ s2, m1, e1);
    end
  endtask

  // One full transaction: accept, settle, optional backpressure, release
  task automatic serveOne(input bit dropReq, input int rdyDelay);
    int g, c;
    logic [31:0] q;
    g = refPick(req, lastGrant);
    if (g < 0) g = 0;
    q = expQ[g];
    c = 0;
    do begin
      tick();
      c++;
    end while (ack == '0 && c < 20);
    checkOutput("ackWait", c, 1);
    checkOutput("ackGrant", 32'(ack), 32'(1 << g));
    checkOutput("busyAfterAck", 32'(busy), 1);
    lastGrant = g;
    if (dropReq) req[g] = 1'b0;
    opA[g]  = 32'h3F80_0000;
    opB[g]  = 32'h3F80_0000;
    expQ[g] = 32'h3F80_0000;
    applyStimulus();
    c = 0;
    do begin
      tick();
      c++;
      if (c == 1) checkOutput("ackPulse", 32'(ack), 0);
    end while (valid == '0 && c < 20);
    checkOutput("latency", c, WAIT_CYCLES);
    checkOutput("validLane", 32'(valid), 32'(1 << g));
    checkOutput("result", result, q);
    if (rdyDelay > 0) begin
      rdy    = '1;
      rdy[g] = 1'b0;
      for (int i = 0; i < rdyDelay; i++) begin
        tick();
        checkOutput("holdValid", 32'(valid), 32'(1 << g));
        checkOutput("holdResult", result, q);
        checkOutput("noAckInDone", 32'(ack), 0);
      end
    end
    rdy = '1;
    tick();
    checkOutput("validCleared", 32'(valid), 0);
    checkOutput("ackWhileLeaving", 32'(ack), 0);
    checkOutput("idleBusy", 32'(busy), 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = '0;
    rdy = '1;
    applyStimulus();
    tick();
    tick();
    rst = 1'b0;
    lastGrant = N_REQ - 1;
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      opA[i]  = '0;
      opB[i]  = '0;
      expQ[i] = '0;
    end
    doReset();
    checkOutput("rstAck", 32'(ack), 0);
    checkOutput("rstValid", 32'(valid), 0);
    checkOutput("rstResult", result, 0);
    checkOutput("rstBusy", 32'(busy), 0);

    $display("[TB] single requester 6.0 / 2.0");
    opA[0] = 32'h40C0_0000; opB[0] = 32'h4000_0000; expQ[0] = 32'h4040_0000;
    req = 4'b0001;
    applyStimulus();
    serveOne(1'b1, 0);

    $display("[TB] simultaneous requesters 0 and 2 from reset");
    doReset();
    opA[0] = 32'h4040_0000; opB[0] = 32'h3F80_0000; expQ[0] = 32'h4040_0000;
    opA[2] = 32'h3F80_0000; opB[2] = 32'h4000_0000; expQ[2] = 32'h3F00_0000;
    req = 4'b0101;
    applyStimulus();
    serveOne(1'b1, 0);
    serveOne(1'b1, 0);

    $display("[TB] operand change after ack on requester 1");
    randomOperands(1);
    req = 4'b0010;
    applyStimulus();
    serveOne(1'b1, 0);

    $display("[TB] backpressure with a competing request");
    randomOperands(1);
    randomOperands(3);
    req = 4'b1010;
    applyStimulus();
    serveOne(1'b1, 5);
    serveOne(1'b1, 0);

    $display("[TB] all requesters continuously");
    doReset();
    for (int i = 0; i < N_REQ; i++) randomOperands(i);
    req = '1;
    applyStimulus();
    for (int n = 0; n < 8; n++) serveOne(1'b0, 0);
    req = '0;
    applyStimulus();

    $display("[TB] reset during BUSY");
    randomOperands(2);
    req = 4'b0100;
    applyStimulus();
    tick();
    checkOutput("midAck", 32'(ack), 32'(1 << refPick(4'b0100, lastGrant)));
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lastGrant = N_REQ - 1;
    checkOutput("midRstAck", 32'(ack), 0);
    checkOutput("midRstValid", 32'(valid), 0);
    checkOutput("midRstResult", result, 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    for (int i = 0; i < WAIT_CYCLES + 3; i++) begin
      tick();
      checkOutput("noGhostValid", 32'(valid), 0);
    end
    randomOperands(0);
    randomOperands(3);
    req = 4'b1001;
    applyStimulus();
    serveOne(1'b1, 0);
    serveOne(1'b1, 0);

    $display("[TB] random request mixes");
    for (int r = 0; r < 6; r++) begin
      logic [N_REQ-1:0] mask;
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++)
        if (mask[i]) randomOperands(i);
      req = mask;
      applyStimulus();
      while (req != '0) serveOne(1'b1, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
Shares one combinational FP_Div instance between N_REQ requesters using round-robin arbitration. It registers the winning operands and gives the long divider path a fixed multicycle settle window of WAIT_CYCLES. It then captures the quotient and returns it to the granted requester over a valid/ready handshake. It sits between the pipeline's per-lane FP issue logic and the single shared IEEE-754 single-precision divider.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8
WAIT_CYCLES, 3, cycles operands are held stable on FP_Div before the result is sampled; legal range 1..15
FP_W, 32, float width; fixed at 32

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  synchronous active-high reset
in_req  input  N_REQ  per-requester division request; held until acked
in_numA  input  N_REQ*FP_W  dividends; requester i uses bits [i*32+:32]
in_numB  input  N_REQ*FP_W  divisors; same packing as in_numA
in_rdy  input  N_REQ  per-requester readiness to accept a result
out_ack  output  N_REQ  one-hot, one-cycle pulse: the request was accepted and its operands latched
out_valid  output  N_REQ  one-hot: out_result belongs to this requester
out_result  output  FP_W  captured quotient
out_busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock in_clk; in_rst is synchronous and active-high.
- Reset values: state=IDLE; out_ack=0; out_valid=0; out_result=0; out_busy=0; operand regs=0; counter=0; last_grant=N_REQ-1, so requester 0 has top priority after reset.
- Reset mid-operation: the in-flight operation is discarded; no out_valid is ever produced for it.
- States: IDLE, BUSY, DONE.
- IDLE, with in_req≠0 at edge E0:
  - pick the first set bit searching from (last_grant+1) mod N_REQ upward with wrap; call it g.
  - latch in_numA[g] and in_numB[g] into the operand regs that drive FP_Div.
  - last_grant←g; out_ack←one-hot(g) for exactly the cycle after E0.
  - counter←WAIT_CYCLES-1; state←BUSY.
- IDLE, with in_req=0: hold.
- BUSY: counter decrements each edge. At the edge where counter==0 (E0+WAIT_CYCLES):
  - out_result←FP_Div out_result.
  - out_valid←one-hot(g); state←DONE.
- DONE:
  - out_valid and out_result hold stable while in_rdy[g]=0.
  - At an edge with in_rdy[g]=1: out_valid←0, state←IDLE.
  - in_rdy bits other than g are ignored.
- Latency and throughput: result is visible WAIT_CYCLES cycles after acceptance. Back-to-back issue rate is one operation per WAIT_CYCLES+2 cycles, since IDLE always lasts at least one cycle.
- Request-side rules:
  - New requests are not sampled outside IDLE.
  - A requester whose req drops before being acked is simply not served.
  - After ack the requester must deassert req or it re-enters arbitration; it is still fair-queued after the other requesters.
  - Operand changes after ack have no effect because the operand regs are frozen through BUSY and DONE.
- Arithmetic: the block never inspects or modifies float values. Special values (zero divisor, NaN, Inf) pass through exactly as FP_Div produces them.

Decomposition:
- Package fp_div_arb_pkg holds: the state enum (IDLE/BUSY/DONE), FP_W=32, and a CNT_W=$clog2(15+1) counter-width constant.
- One sub-module: rr_arbiter. Inputs: request vector and last_grant. Output: one-hot grant plus index. Purely combinational.
- FP_Div is instantiated unchanged inside the block.

Test Plan:
- Single requester 0 sends A=0x40C00000 (6.0), B=0x40000000 (2.0), WAIT_CYCLES=3 with in_rdy=1 → out_ack=0001 for one cycle after acceptance; out_valid=0001 with out_result=0x40400000 exactly 3 cycles after acceptance; back to IDLE one cycle later.
- Requesters 0 and 2 request simultaneously from reset, with 3.0/1.0 (0x40400000/0x3F800000) and 1.0/2.0 (0x3F800000/0x40000000) → requester 0 served first with 0x40400000, then requester 2 with 0x3F000000.
- All four requesters request continuously for 8 operations → grant order 0,1,2,3,0,1,2,3; no requester granted twice in a row.
- Backpressure: in_rdy[g]=0 for 5 cycles in DONE → out_valid and out_result remain constant; a new request on another lane gets no out_ack until 1 cycle after in_rdy[g] rises.
- Operand change after ack: requester 1 switches its operands to 0x3F800000/0x3F800000 during BUSY → result still matches the latched operands.
- in_rst pulsed during BUSY → all outputs return to 0 on the next edge; no out_valid for the aborted operation; the next request from requester 0 is granted first.
